// File: rtl/onehot_pkg.sv
// Shared types and sizing for the binary-to-one-hot pulse driver.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int BIN_W_DEF = 4;
  localparam int OH_W      = 2 ** BIN_W_DEF;
  localparam int CNT_W     = 8;

endpackage : onehot_pkg

// File: rtl/bin2onehot.sv
// Combinational binary-to-one-hot decoder; all-zero output while valid is low.
module bin2onehot #(
  parameter int BIN_W = 4
) (
  input  logic [BIN_W-1:0]      bin,
  input  logic                  valid,
  output logic [2**BIN_W-1:0]   onehot
);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    onehot = '0;
    if (valid) onehot[bin] = 1'b1;
  end

endmodule : bin2onehot

// File: rtl/onehot_pulse_driver.sv
// Drives one one-hot line per accepted index for HOLD_CYCLES, followed by an
// all-zero break-before-make gap of GAP_CYCLES.
module onehot_pulse_driver
  import onehot_pkg::*;
#(
  parameter int BIN_W       = BIN_W_DEF,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BIN_W-1:0]     bin_in,
  input  logic                 bin_valid,
  output logic                 bin_ready,
  output logic [2**BIN_W-1:0]  onehot_out,
  output logic                 onehot_active,
  output logic                 busy
);

  localparam int               OHW       = 2 ** BIN_W;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OHW-1:0]   onehot_q, onehot_d;
  logic             active_q, active_d;
  logic [OHW-1:0]   dec_onehot;
  logic             accept;

  assign bin_ready = rst_n && enable && (state_q == IDLE);
  assign accept    = bin_valid && bin_ready;

  bin2onehot #(.BIN_W(BIN_W)) u_dec (
    .bin    (bin_in),
    .valid  (accept),
    .onehot (dec_onehot)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          cnt_d   = HOLD_LOAD;
        end
      end
      DRIVE: begin
        // Dropping enable ends the code early but still honours the full gap.
        if (!enable || cnt_q == '0) begin
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The line is only ever nonzero while heading into DRIVE, which keeps
  // the output one-hot-or-zero even from an illegal state encoding.
  always_comb begin
    onehot_d = '0;
    if (state_d == DRIVE) onehot_d = (state_q == IDLE) ? dec_onehot : onehot_q;
    active_d = |onehot_d;
  end

  assign onehot_out    = onehot_q;
  assign onehot_active = active_q;
  assign busy          = (state_q != IDLE);

endmodule : onehot_pulse_driver

// File: tb/tb_onehot_pulse_driver.sv
// Self-checking bench: default-parameter instance plus a HOLD=1/GAP=0 instance.
module tb_onehot_pulse_driver;
  import onehot_pkg::*;

  typedef struct packed {
    logic [OH_W-1:0] oh;
    logic            rdy;
    logic            busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable, bin_valid, bin_ready, onehot_active, busy;
  logic [3:0]      bin_in;
  logic [OH_W-1:0] onehot_out;
  logic            enable_p, bin_valid_p, bin_ready_p, onehot_active_p, busy_p;
  logic [3:0]      bin_in_p;
  logic [OH_W-1:0] onehot_out_p;

  exp_t sb[$];
  exp_t exp_v, obs_v;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  onehot_pulse_driver u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bin_in(bin_in),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .onehot_out(onehot_out),
    .onehot_active(onehot_active), .busy(busy)
  );

  onehot_pulse_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .enable(enable_p), .bin_in(bin_in_p),
    .bin_valid(bin_valid_p), .bin_ready(bin_ready_p), .onehot_out(onehot_out_p),
    .onehot_active(onehot_active_p), .busy(busy_p)
  );

  function automatic exp_t mk(input logic [OH_W-1:0] oh, input logic rdy, input logic bsy);
    mk = '{oh: oh, rdy: rdy, busy: bsy};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; bin_valid = 1'b0; bin_in = '0;
    enable_p = 1'b1; bin_valid_p = 1'b0; bin_in_p = '0;
    repeat (3) @(negedge clk);
    obs_v = '{onehot_out, bin_ready, busy};
    checks++;
    if (obs_v !== mk('0, 1'b0, 1'b0) || onehot_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got oh=%h rdy=%b busy=%b act=%b, want 0/0/0/0",
               onehot_out, bin_ready, busy, onehot_active);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs_v = '{onehot_out, bin_ready, busy};
    checks++;
    if (obs_v !== mk('0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL reset_release: got oh=%h rdy=%b busy=%b, want oh=0 rdy=1 busy=0",
               onehot_out, bin_ready, busy);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) sb.push_back(mk(16'h0040, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b1, 1'b0));
    bin_in = 4'd6; bin_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bin_valid = 1'b0; bin_in = 4'd13;
      exp_v = sb.pop_front();
      obs_v = '{onehot_out, bin_ready, busy};
      checks++;
      if (obs_v !== exp_v || onehot_active !== (|exp_v.oh)) begin
        errors++;
        $display("FAIL single[%0d]: got oh=%h rdy=%b busy=%b act=%b, want oh=%h rdy=%b busy=%b",
                 i, onehot_out, bin_ready, busy, onehot_active, exp_v.oh, exp_v.rdy, exp_v.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) sb.push_back(mk(16'h0001, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) sb.push_back(mk(16'h8000, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b1, 1'b0));
    bin_in = 4'd0; bin_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bin_in = 4'd15;
      if (i == 6) bin_valid = 1'b0;
      exp_v = sb.pop_front();
      obs_v = '{onehot_out, bin_ready, busy};
      checks++;
      if (obs_v !== exp_v || !$onehot0(onehot_out)) begin
        errors++;
        $display("FAIL b2b[%0d]: got oh=%h rdy=%b busy=%b, want oh=%h rdy=%b busy=%b",
                 i, onehot_out, bin_ready, busy, exp_v.oh, exp_v.rdy, exp_v.busy);
      end
    end
  endtask

  task automatic test_abort();
    sb.push_back(mk(16'h0200, 1'b0, 1'b1));
    sb.push_back(mk(16'h0200, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b0, 1'b1));
    sb.push_back(mk('0, 1'b0, 1'b0));
    sb.push_back(mk('0, 1'b0, 1'b0));
    sb.push_back(mk('0, 1'b1, 1'b0));
    bin_in = 4'd9; bin_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = '{onehot_out, bin_ready, busy};
      checks++;
      if (obs_v !== exp_v || onehot_active !== (|exp_v.oh)) begin
        errors++;
        $display("FAIL abort[%0d]: got oh=%h rdy=%b busy=%b act=%b, want oh=%h rdy=%b busy=%b",
                 i, onehot_out, bin_ready, busy, onehot_active, exp_v.oh, exp_v.rdy, exp_v.busy);
      end
      case (i)
        0:       bin_valid = 1'b0;
        1:       enable = 1'b0;
        3:       begin bin_valid = 1'b1; bin_in = 4'd2; end
        4:       begin enable = 1'b1; bin_valid = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    bin_in = 4'd11; bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    checks++;
    if (onehot_out !== 16'h0800) begin
      errors++;
      $display("FAIL areset_pre: got oh=%h, want oh=0800", onehot_out);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs_v = '{onehot_out, bin_ready, busy};
    checks++;
    if (obs_v !== mk('0, 1'b0, 1'b0) || onehot_active !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: got oh=%h rdy=%b busy=%b act=%b, want 0/0/0/0",
               onehot_out, bin_ready, busy, onehot_active);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    obs_v = '{onehot_out, bin_ready, busy};
    checks++;
    if (obs_v !== mk('0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL areset_after: got oh=%h rdy=%b busy=%b, want oh=0 rdy=1 busy=0",
               onehot_out, bin_ready, busy);
    end
  endtask

  task automatic test_param_sweep();
    logic [3:0] idx_tbl [3];
    idx_tbl[0] = 4'd3; idx_tbl[1] = 4'd4; idx_tbl[2] = 4'd5;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(OH_W'(1) << idx_tbl[k], 1'b0, 1'b1));
      sb.push_back(mk('0, 1'b1, 1'b0));
    end
    bin_in_p = idx_tbl[0]; bin_valid_p = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5)      bin_valid_p = 1'b0;
      else if (i < 4)  bin_in_p = idx_tbl[(i + 2) / 2];
      exp_v = sb.pop_front();
      obs_v = '{onehot_out_p, bin_ready_p, busy_p};
      checks++;
      if (obs_v !== exp_v || onehot_active_p !== (|exp_v.oh)) begin
        errors++;
        $display("FAIL sweep[%0d]: got oh=%h rdy=%b busy=%b act=%b, want oh=%h rdy=%b busy=%b",
                 i, onehot_out_p, bin_ready_p, busy_p, onehot_active_p, exp_v.oh, exp_v.rdy, exp_v.busy);
      end
    end
    bin_valid_p = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_onehot_pulse_driver
